// File: rtl/plab3_mem_line_mem_responder_if.sv
// Line-wide memory request/response channel between the
// blocking cache (master) and the line memory responder (slave).
interface plab3_mem_line_mem_responder_if #(
  parameter int p_opaque_nbits = 8,
  parameter int abw = 32,
  parameter int clw = 128
);
  localparam int reqw = 3 + p_opaque_nbits + abw + 4 + clw;
  localparam int respw = 3 + p_opaque_nbits + 4 + clw;

  logic             domain;
  logic             memreq_val;
  logic             memreq_rdy;
  logic [reqw-1:0]  memreq_msg;
  logic             memresp_val;
  logic             memresp_rdy;
  logic [respw-1:0] memresp_msg;
  logic             insecure;
  logic             resp_domain;

  modport master (
    output domain,
    output memreq_val,
    output memreq_msg,
    output memresp_rdy,
    input  memreq_rdy,
    input  memresp_val,
    input  memresp_msg,
    input  insecure,
    input  resp_domain
  );

  modport slave (
    input  domain,
    input  memreq_val,
    input  memreq_msg,
    input  memresp_rdy,
    output memreq_rdy,
    output memresp_val,
    output memresp_msg,
    output insecure,
    output resp_domain
  );
endinterface

// File: rtl/plab3_mem_line_mem_responder.sv
// Single-outstanding line memory with per-line domain owner tags;
// cross-domain accesses are refused and reported on insecure.
module plab3_mem_line_mem_responder #(
  parameter int p_opaque_nbits = 8,
  parameter int abw = 32,
  parameter int clw = 128,
  parameter int nlines = 64,
  parameter int p_latency = 2
) (
  input logic clk,
  input logic reset,
  plab3_mem_line_mem_responder_if.slave mem
);
  localparam int o = p_opaque_nbits;
  localparam int iw = $clog2(nlines);
  localparam int lenlo = clw;
  localparam int alo = clw + 4;
  localparam int olo = alo + abw;
  localparam int tlo = olo + o;

  localparam logic [2:0] T_READ = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;
  localparam logic [2:0] T_INIT = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic access;

  logic [2:0]     q_type;
  logic [o-1:0]   q_opaque;
  logic [iw-1:0]  q_idx;
  logic [clw-1:0] q_data;
  logic           q_dom;

  logic [clw-1:0]    line_data [nlines];
  logic [nlines-1:0] line_val;
  logic [nlines-1:0] line_own;

  logic [2:0]     r_type;
  logic [o-1:0]   r_opaque;
  logic [clw-1:0] r_data;
  logic           r_insecure;
  logic           r_dom;

  logic [2:0]     in_type;
  logic [o-1:0]   in_opaque;
  logic [iw-1:0]  in_idx;
  logic [clw-1:0] in_data;

  assign in_type = mem.memreq_msg[tlo +: 3];
  assign in_opaque = mem.memreq_msg[olo +: o];
  assign in_idx = mem.memreq_msg[alo+4 +: iw];
  assign in_data = mem.memreq_msg[0 +: clw];

  logic unused_bits;
  assign unused_bits = ^{mem.memreq_msg[lenlo +: 4],
                         mem.memreq_msg[alo +: 4],
                         mem.memreq_msg[tlo-1 : alo+4+iw]};

  // With zero latency the store is accessed straight from the
  // incoming request, so the access operands bypass the capture regs.
  logic           from_in;
  logic [2:0]     a_type;
  logic [o-1:0]   a_opaque;
  logic [iw-1:0]  a_idx;
  logic [clw-1:0] a_data;
  logic           a_dom;

  assign from_in = (state == IDLE);
  assign a_type = from_in ? in_type : q_type;
  assign a_opaque = from_in ? in_opaque : q_opaque;
  assign a_idx = from_in ? in_idx : q_idx;
  assign a_data = from_in ? in_data : q_data;
  assign a_dom = from_in ? mem.domain : q_dom;

  logic is_wr;
  logic deny;
  logic wr_en;
  logic [2:0] a_rtype;

  always_comb begin
    is_wr = 1'b0;
    a_rtype = T_READ;
    unique case (1'b1)
      (a_type == T_WRITE): begin
        is_wr = 1'b1;
        a_rtype = T_WRITE;
      end
      (a_type == T_INIT): begin
        is_wr = 1'b1;
        a_rtype = T_INIT;
      end
      default: begin
        is_wr = 1'b0;
        a_rtype = T_READ;
      end
    endcase
  end

  assign deny = line_val[a_idx] && (line_own[a_idx] != a_dom);
  assign wr_en = access && is_wr && !deny;

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    access = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem.memreq_val) begin
          if (p_latency == 0) begin
            state_nxt = RESP;
            access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt = 4'(p_latency - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (mem.memresp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_type <= '0;
      q_opaque <= '0;
      q_idx <= '0;
      q_data <= '0;
      q_dom <= 1'b0;
    end else if (state == IDLE && mem.memreq_val) begin
      q_type <= in_type;
      q_opaque <= in_opaque;
      q_idx <= in_idx;
      q_data <= in_data;
      q_dom <= mem.domain;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_val <= '0;
      line_own <= '0;
    end else if (wr_en) begin
      line_val[a_idx] <= 1'b1;
      line_own[a_idx] <= a_dom;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_data[a_idx] <= a_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_type <= '0;
      r_opaque <= '0;
      r_data <= '0;
      r_insecure <= 1'b0;
      r_dom <= 1'b0;
    end else if (access) begin
      r_type <= a_rtype;
      r_opaque <= a_opaque;
      r_insecure <= deny;
      r_dom <= a_dom;
      if (!is_wr && !deny && line_val[a_idx])
        r_data <= line_data[a_idx];
      else
        r_data <= '0;
    end
  end

  assign mem.memreq_rdy = (state == IDLE);
  assign mem.memresp_val = (state == RESP);
  assign mem.memresp_msg = {r_type, r_opaque, 4'd0, r_data};
  assign mem.insecure = (state == RESP) && r_insecure;
  assign mem.resp_domain = r_dom;
endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Directed bench: one DUT at latency 2 and one at latency 0,
// sharing clock and reset.
module tb_plab3_mem_line_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  plab3_mem_line_mem_responder_if m2 ();
  plab3_mem_line_mem_responder_if m0 ();

  plab3_mem_line_mem_responder #(.p_latency(2)) u_lat2 (
    .clk(clk),
    .reset(rst_n),
    .mem(m2)
  );

  plab3_mem_line_mem_responder #(.p_latency(0)) u_lat0 (
    .clk(clk),
    .reset(rst_n),
    .mem(m0)
  );

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hCAFEF00D_12345678_9ABCDEF0_DEADBEEF;
  localparam logic [127:0] D3 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] ONES = {128{1'b1}};

  function automatic logic [174:0] mk(input logic [2:0] t,
                                      input logic [7:0] op,
                                      input logic [31:0] a,
                                      input logic [127:0] d);
    return {t, op, a, 4'hF, d};
  endfunction

  function automatic logic g_rdy(input bit l0);
    return l0 ? m0.memreq_rdy : m2.memreq_rdy;
  endfunction

  function automatic logic g_val(input bit l0);
    return l0 ? m0.memresp_val : m2.memresp_val;
  endfunction

  function automatic logic [142:0] g_msg(input bit l0);
    return l0 ? m0.memresp_msg : m2.memresp_msg;
  endfunction

  function automatic logic g_ins(input bit l0);
    return l0 ? m0.insecure : m2.insecure;
  endfunction

  function automatic logic g_dom(input bit l0);
    return l0 ? m0.resp_domain : m2.resp_domain;
  endfunction

  task automatic drive(input bit l0, input logic v,
                       input logic [174:0] msg, input logic dom,
                       input logic rr);
    if (l0) begin
      m0.memreq_val = v;
      m0.memreq_msg = msg;
      m0.domain = dom;
      m0.memresp_rdy = rr;
    end else begin
      m2.memreq_val = v;
      m2.memreq_msg = msg;
      m2.domain = dom;
      m2.memresp_rdy = rr;
    end
  endtask

  // One full transaction; returns latency counted in cycles
  // after the accept edge, and the response observed.
  task automatic xact(input bit l0, input logic [2:0] t,
                      input logic [7:0] op, input logic [31:0] a,
                      input logic [127:0] d, input logic dom,
                      output int lat, output logic [142:0] msg,
                      output logic ins, output logic rdom);
    @(negedge clk);
    drive(l0, 1'b1, mk(t, op, a, d), dom, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(l0, 1'b0, '0, 1'b0, 1'b1);
    lat = 1;
    while (!g_val(l0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!g_val(l0)) begin
      bad++;
      $display("FAIL resp_timeout: val=%0b required=1", g_val(l0));
    end
    msg = g_msg(l0);
    ins = g_ins(l0);
    rdom = g_dom(l0);
    @(negedge clk);
    total++;
    if (g_rdy(l0) !== 1'b1) begin
      bad++;
      $display("FAIL rdy_after_resp: got=%0b required=1", g_rdy(l0));
    end
  endtask

  int lat;
  logic [142:0] msg;
  logic ins;
  logic rdom;

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (m2.memreq_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy: got=%0b required=1", m2.memreq_rdy);
    end
    total++;
    if ({m2.memresp_val, m2.insecure, m2.resp_domain} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: val/ins/dom=%03b required=000",
               {m2.memresp_val, m2.insecure, m2.resp_domain});
    end
    total++;
    if (m2.memresp_msg !== 143'd0) begin
      bad++;
      $display("FAIL reset_msg: got=%h required=0", m2.memresp_msg);
    end
  endtask

  task automatic test_read_empty();
    xact(1'b0, 3'd0, 8'h33, 32'h40, ONES, 1'b0, lat, msg, ins, rdom);
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL empty_lat: got=%0d required=3", lat);
    end
    total++;
    if (msg !== {3'd0, 8'h33, 4'd0, 128'd0} || ins !== 1'b0) begin
      bad++;
      $display("FAIL empty_read: msg=%h ins=%0b required data 0 ins 0",
               msg, ins);
    end
  endtask

  task automatic test_write_read();
    xact(1'b0, 3'd1, 8'h5A, 32'h30, D1, 1'b0, lat, msg, ins, rdom);
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL write_lat: got=%0d required=3", lat);
    end
    total++;
    if (msg !== {3'd1, 8'h5A, 4'd0, 128'd0} || ins !== 1'b0) begin
      bad++;
      $display("FAIL write_resp: msg=%h ins=%0b", msg, ins);
    end
    xact(1'b0, 3'd0, 8'h11, 32'h30, '0, 1'b0, lat, msg, ins, rdom);
    total++;
    if (msg !== {3'd0, 8'h11, 4'd0, D1} || ins !== 1'b0) begin
      bad++;
      $display("FAIL read_back: msg=%h required data=%h", msg, D1);
    end
    xact(1'b0, 3'd5, 8'h22, 32'h30, '0, 1'b0, lat, msg, ins, rdom);
    total++;
    if (msg !== {3'd0, 8'h22, 4'd0, D1}) begin
      bad++;
      $display("FAIL unknown_type: msg=%h required type 0 data=%h",
               msg, D1);
    end
    xact(1'b0, 3'd2, 8'h23, 32'h50, D3, 1'b0, lat, msg, ins, rdom);
    total++;
    if (msg !== {3'd2, 8'h23, 4'd0, 128'd0} || ins !== 1'b0) begin
      bad++;
      $display("FAIL write_init: msg=%h ins=%0b", msg, ins);
    end
  endtask

  task automatic test_cross_domain();
    xact(1'b0, 3'd1, 8'h01, 32'h100, D2, 1'b0, lat, msg, ins, rdom);
    xact(1'b0, 3'd0, 8'h02, 32'h100, '0, 1'b1, lat, msg, ins, rdom);
    total++;
    if (msg !== {3'd0, 8'h02, 4'd0, 128'd0} || ins !== 1'b1) begin
      bad++;
      $display("FAIL xdom_read: msg=%h ins=%0b required data 0 ins 1",
               msg, ins);
    end
    total++;
    if (rdom !== 1'b1) begin
      bad++;
      $display("FAIL xdom_resp_domain: got=%0b required=1", rdom);
    end
    xact(1'b0, 3'd1, 8'h03, 32'h100, ONES, 1'b1, lat, msg, ins, rdom);
    total++;
    if (msg[142:140] !== 3'd1 || ins !== 1'b1) begin
      bad++;
      $display("FAIL xdom_write: type=%0d ins=%0b required 1/1",
               msg[142:140], ins);
    end
    xact(1'b0, 3'd0, 8'h04, 32'h100, '0, 1'b0, lat, msg, ins, rdom);
    total++;
    if (msg[127:0] !== D2 || ins !== 1'b0 || rdom !== 1'b0) begin
      bad++;
      $display("FAIL owner_read: data=%h ins=%0b required %h 0",
               msg[127:0], ins, D2);
    end
  endtask

  task automatic test_backpressure();
    logic [142:0] held;
    int n;
    @(negedge clk);
    drive(1'b0, 1'b1, mk(3'd0, 8'h77, 32'h30, '0), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, mk(3'd1, 8'h99, 32'h30, ONES), 1'b1, 1'b0);
    n = 0;
    while (!m2.memresp_val && n < 40) begin
      @(negedge clk);
      n++;
    end
    held = m2.memresp_msg;
    total++;
    if (held !== {3'd0, 8'h77, 4'd0, D1}) begin
      bad++;
      $display("FAIL bp_first: msg=%h required data=%h", held, D1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (m2.memresp_val !== 1'b1 || m2.memresp_msg !== held ||
          m2.memreq_rdy !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: val=%0b rdy=%0b msg=%h", i,
                 m2.memresp_val, m2.memreq_rdy, m2.memresp_msg);
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (m2.memreq_rdy !== 1'b1 || m2.memresp_val !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: rdy=%0b val=%0b required 1/0",
               m2.memreq_rdy, m2.memresp_val);
    end
  endtask

  task automatic test_alias_lat0();
    xact(1'b1, 3'd1, 8'h0A, 32'h10, D3, 1'b0, lat, msg, ins, rdom);
    total++;
    if (lat != 1 || msg !== {3'd1, 8'h0A, 4'd0, 128'd0}) begin
      bad++;
      $display("FAIL lat0_write: lat=%0d msg=%h required lat 1",
               lat, msg);
    end
    xact(1'b1, 3'd0, 8'h0B, 32'h410, '0, 1'b0, lat, msg, ins, rdom);
    total++;
    if (lat != 1 || msg !== {3'd0, 8'h0B, 4'd0, D3}) begin
      bad++;
      $display("FAIL alias_read: lat=%0d msg=%h required lat 1 data=%h",
               lat, msg, D3);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    xact(1'b0, 3'd1, 8'h41, 32'h200, D4, 1'b0, lat, msg, ins, rdom);
    @(negedge clk);
    drive(1'b0, 1'b1, mk(3'd0, 8'h42, 32'h200, '0), 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m2.memresp_val) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_drop: resp cycles=%0d required=0", seen);
    end
    xact(1'b0, 3'd0, 8'h43, 32'h200, '0, 1'b0, lat, msg, ins, rdom);
    total++;
    if (msg !== {3'd0, 8'h43, 4'd0, 128'd0} || ins !== 1'b0) begin
      bad++;
      $display("FAIL reset_invalid: msg=%h ins=%0b required data 0",
               msg, ins);
    end
    xact(1'b0, 3'd0, 8'h44, 32'h100, '0, 1'b1, lat, msg, ins, rdom);
    total++;
    if (ins !== 1'b0 || msg[127:0] !== 128'd0) begin
      bad++;
      $display("FAIL reset_owner: ins=%0b data=%h required 0/0",
               ins, msg[127:0]);
    end
  endtask

  initial begin
    test_reset();
    test_read_empty();
    test_write_read();
    test_cross_domain();
    test_backpressure();
    test_alias_lat0();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
